// File: rtl/seq_checker.sv
// Receive-side checker for the repeating 000 -> 010 -> 011 -> 101 pattern.
// It finds the phase, locks after a run of correct symbols, and counts errors while locked.
module seq_checker #(
    parameter int LOCK_THRESH   = 4,
    parameter int UNLOCK_THRESH = 2,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [2:0]           in_data,
    input  logic                 err_clr,
    output logic                 locked,
    output logic                 match,
    output logic                 error,
    output logic                 illegal,
    output logic [2:0]           expected,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2,
        SLIP   = 2'd3
    } state_t;

    localparam logic [3:0] LOCK_T   = 4'(LOCK_THRESH);
    localparam logic [3:0] UNLOCK_T = 4'(UNLOCK_THRESH);

    // Handshake: a symbol is consumed on a rising edge where in_valid=1; there is no backpressure.

    state_t     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [3:0] run_q, run_d;
    logic [3:0] miss_q, miss_d;
    logic [2:0] expected_q, expected_d;
    logic       match_d, error_d, illegal_d, load_exp;
    logic       sym_legal, hit;
    logic [1:0] sym_idx;
    logic [3:0] run_inc, miss_inc;

    function automatic logic [2:0] sym_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return 3'b000;
            2'd1:    return 3'b010;
            2'd2:    return 3'b011;
            default: return 3'b101;
        endcase
    endfunction

    always_comb begin
        sym_legal = 1'b1;
        sym_idx   = 2'd0;
        case (in_data)
            3'b000:  sym_idx = 2'd0;
            3'b010:  sym_idx = 2'd1;
            3'b011:  sym_idx = 2'd2;
            3'b101:  sym_idx = 2'd3;
            default: sym_legal = 1'b0;
        endcase
    end

    assign hit      = (in_data == sym_of(phase_q + 2'd1));
    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        run_d      = run_q;
        miss_d     = miss_q;
        expected_d = expected_q;
        match_d    = 1'b0;
        error_d    = 1'b0;
        illegal_d  = 1'b0;
        load_exp   = 1'b0;
        if (in_valid) begin
            illegal_d = !sym_legal;
            case (state_q)
                HUNT: begin
                    if (sym_legal) begin
                        phase_d  = sym_idx;
                        run_d    = 4'd1;
                        miss_d   = 4'd0;
                        load_exp = 1'b1;
                        state_d  = VERIFY;
                    end
                end
                VERIFY: begin
                    match_d = hit;
                    if (hit) begin
                        phase_d  = phase_q + 2'd1;
                        run_d    = run_inc;
                        load_exp = 1'b1;
                        if (run_inc >= LOCK_T) begin
                            state_d = LOCKED;
                            miss_d  = 4'd0;
                        end
                    end else if (sym_legal) begin
                        phase_d  = sym_idx;
                        run_d    = 4'd1;
                        load_exp = 1'b1;
                    end else begin
                        run_d   = 4'd0;
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Once locked the phase free-runs; a bad symbol never re-seeds it.
                    match_d  = hit;
                    phase_d  = phase_q + 2'd1;
                    load_exp = 1'b1;
                    if (!hit) begin
                        error_d = 1'b1;
                        miss_d  = 4'd1;
                        state_d = (UNLOCK_T <= 4'd1) ? HUNT : SLIP;
                    end
                end
                default: begin
                    match_d  = hit;
                    phase_d  = phase_q + 2'd1;
                    load_exp = 1'b1;
                    if (hit) begin
                        miss_d  = 4'd0;
                        state_d = LOCKED;
                    end else begin
                        error_d = 1'b1;
                        miss_d  = miss_inc;
                        if (miss_inc >= UNLOCK_T) state_d = HUNT;
                    end
                end
            endcase
            if (load_exp) expected_d = sym_of(phase_d + 2'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= HUNT;
            phase_q    <= 2'd0;
            run_q      <= 4'd0;
            miss_q     <= 4'd0;
            expected_q <= 3'b000;
            match      <= 1'b0;
            error      <= 1'b0;
            illegal    <= 1'b0;
            locked     <= 1'b0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            expected_q <= expected_d;
            match      <= match_d;
            error      <= error_d;
            illegal    <= illegal_d;
            locked     <= (state_d == LOCKED) || (state_d == SLIP);
            // Clear wins over a same-cycle increment; the count sticks at all-ones.
            if (err_clr)
                err_count <= '0;
            else if (error_d && (err_count != {ERR_CNT_W{1'b1}}))
                err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    assign expected  = expected_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_checker.sv
// Bench for seq_checker: directed vector table, hand-written corner sequences,
// and a random stream checked against a behavioural model of the pattern rules.
module tb_seq_checker;

    localparam int LT = 4;
    localparam int UT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [2:0] in_data = 3'd0;
    logic       err_clr = 1'b0;

    logic       locked8, match8, error8, illegal8;
    logic [2:0] expected8;
    logic [7:0] cnt8;
    logic [1:0] dbg8;
    logic       locked2, match2, error2, illegal2;
    logic [2:0] expected2;
    logic [1:0] cnt2;
    logic [1:0] dbg2;

    seq_checker #(.LOCK_THRESH(LT), .UNLOCK_THRESH(UT), .ERR_CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
        .locked(locked8), .match(match8), .error(error8), .illegal(illegal8),
        .expected(expected8), .err_count(cnt8), .dbg_state(dbg8)
    );

    seq_checker #(.LOCK_THRESH(LT), .UNLOCK_THRESH(UT), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
        .locked(locked2), .match(match2), .error(error2), .illegal(illegal2),
        .expected(expected2), .err_count(cnt2), .dbg_state(dbg2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [2:0] pat [4] = '{3'd0, 3'd2, 3'd3, 3'd5};

    // behavioural model: m_phase < 0 means hunting
    int m_phase = -1;
    int m_run = 0;
    int m_miss = 0;
    bit m_lock = 0;
    bit m_match = 0, m_error = 0, m_illegal = 0;
    int e8 = 0, e2 = 0;

    typedef struct {
        bit         v;
        logic [2:0] d;
        bit         clr;
        bit         lk, m, e, il;
        bit         ce;
        logic [2:0] ex;
        int         cnt;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int idx;
        logic [2:0] due;
        m_match = 0; m_error = 0; m_illegal = 0;
        if (!rst) begin
            m_phase = -1; m_run = 0; m_miss = 0; m_lock = 0; e8 = 0; e2 = 0;
            return;
        end
        if (in_valid) begin
            idx = -1;
            for (int k = 0; k < 4; k++) if (pat[k] == in_data) idx = k;
            m_illegal = (idx < 0);
            if (m_phase < 0) begin
                if (idx >= 0) begin m_phase = idx; m_run = 1; end
            end else begin
                due = pat[(m_phase + 1) % 4];
                m_match = (in_data == due);
                if (!m_lock) begin
                    if (m_match) begin
                        m_phase = (m_phase + 1) % 4;
                        m_run++;
                        if (m_run >= LT) begin m_lock = 1; m_miss = 0; end
                    end else if (idx >= 0) begin
                        m_phase = idx; m_run = 1;
                    end else begin
                        m_phase = -1;
                    end
                end else begin
                    m_phase = (m_phase + 1) % 4;
                    if (m_match) m_miss = 0;
                    else begin
                        m_error = 1;
                        m_miss++;
                        if (m_miss >= UT) begin m_lock = 0; m_phase = -1; end
                    end
                end
            end
        end
        if (err_clr) begin e8 = 0; e2 = 0; end
        else if (m_error) begin
            if (e8 < 255) e8++;
            if (e2 < 3) e2++;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        model_step();
        chk("locked", locked8, m_lock);
        chk("match", match8, m_match);
        chk("error", error8, m_error);
        chk("illegal", illegal8, m_illegal);
        chk("err_count8", cnt8, e8);
        chk("err_count2", cnt2, e2);
        chk("locked_w2", locked2, m_lock);
        chk("hunting", dbg8 == 2'd0, m_phase < 0);
        if (m_phase >= 0) chk("expected", expected8, pat[(m_phase + 1) % 4]);
    endtask

    task automatic send(input bit v, input logic [2:0] d, input bit clr);
        in_valid = v; in_data = d; err_clr = clr;
        cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b1; in_data = 3'b101; err_clr = 1'b0;
        cycle();
        cycle();
        chk("rst_expected", expected8, 3'b000);
        chk("rst_state", dbg8, 2'd0);
        chk("rst_locked", locked8, 1'b0);
        chk("rst_cnt", cnt8, 0);
        rst = 1'b1; in_valid = 1'b0;
    endtask

    function automatic void add(bit v, logic [2:0] d, bit clr, bit lk, bit m, bit e, bit il,
                                bit ce, logic [2:0] ex, int cnt);
        vec_t t;
        t.v = v; t.d = d; t.clr = clr; t.lk = lk; t.m = m; t.e = e; t.il = il;
        t.ce = ce; t.ex = ex; t.cnt = cnt;
        tbl.push_back(t);
    endfunction

    initial begin
        // clean lock
        add(1, 3'd0, 0, 0, 0, 0, 0, 1, 3'd2, 0);
        add(1, 3'd2, 0, 0, 1, 0, 0, 1, 3'd3, 0);
        add(1, 3'd3, 0, 0, 1, 0, 0, 1, 3'd5, 0);
        add(1, 3'd5, 0, 1, 1, 0, 0, 1, 3'd0, 0);
        for (int i = 0; i < 8; i++)
            add(1, pat[i % 4], 0, 1, 1, 0, 0, 1, pat[(i + 1) % 4], 0);
        // single corruption while locked
        add(1, 3'd0, 0, 1, 1, 0, 0, 1, 3'd2, 0);
        add(1, 3'd2, 0, 1, 1, 0, 0, 1, 3'd3, 0);
        add(1, 3'd4, 0, 1, 0, 1, 1, 1, 3'd5, 1);
        add(1, 3'd5, 0, 1, 1, 0, 0, 1, 3'd0, 1);
        // loss of lock on two wrong legal symbols
        add(1, 3'd0, 0, 1, 1, 0, 0, 1, 3'd2, 1);
        add(1, 3'd2, 0, 1, 1, 0, 0, 1, 3'd3, 1);
        add(1, 3'd0, 0, 1, 0, 1, 0, 1, 3'd5, 2);
        add(1, 3'd0, 0, 0, 0, 1, 0, 0, 3'd0, 3);
        // relock, then clear and idle
        add(1, 3'd0, 0, 0, 0, 0, 0, 1, 3'd2, 3);
        add(1, 3'd2, 0, 0, 1, 0, 0, 1, 3'd3, 3);
        add(1, 3'd3, 0, 0, 1, 0, 0, 1, 3'd5, 3);
        add(1, 3'd5, 0, 1, 1, 0, 0, 1, 3'd0, 3);
        add(0, 3'd7, 1, 1, 0, 0, 0, 1, 3'd0, 0);
        add(0, 3'd0, 0, 1, 0, 0, 0, 1, 3'd0, 0);

        do_reset();
        foreach (tbl[i]) begin
            send(tbl[i].v, tbl[i].d, tbl[i].clr);
            chk($sformatf("vec%0d locked", i), locked8, tbl[i].lk);
            chk($sformatf("vec%0d match", i), match8, tbl[i].m);
            chk($sformatf("vec%0d error", i), error8, tbl[i].e);
            chk($sformatf("vec%0d illegal", i), illegal8, tbl[i].il);
            chk($sformatf("vec%0d err_count", i), cnt8, tbl[i].cnt);
            if (tbl[i].ce) chk($sformatf("vec%0d expected", i), expected8, tbl[i].ex);
        end

        // mid-phase start with gaps
        do_reset();
        send(1, 3'd3, 0);
        send(0, 3'd0, 0);
        chk("gap_match", match8, 1'b0);
        send(1, 3'd5, 0);
        send(1, 3'd0, 0);
        send(0, 3'd5, 0);
        chk("gap_locked", locked8, 1'b0);
        send(1, 3'd2, 0);
        chk("mid_locked", locked8, 1'b1);
        chk("mid_expected", expected8, 3'd3);
        chk("mid_error", error8, 1'b0);

        // counter saturation on the narrow instance, then clear against an error
        do_reset();
        for (int i = 0; i < 4; i++) send(1, pat[i], 0);
        for (int k = 0; k < 5; k++) begin
            send(1, 3'd7, 0);
            send(1, pat[(2 * k + 1) % 4], 0);
        end
        chk("sat_cnt2", cnt2, 2'd3);
        chk("sat_cnt8", cnt8, 8'd5);
        chk("sat_locked", locked8, 1'b1);
        send(1, 3'd7, 1);
        chk("clr_error", error8, 1'b1);
        chk("clr_cnt8", cnt8, 8'd0);
        chk("clr_cnt2", cnt2, 2'd0);

        // reset in the middle of VERIFY
        do_reset();
        send(1, 3'd0, 0);
        send(1, 3'd2, 0);
        rst = 1'b0; in_valid = 1'b0;
        cycle();
        chk("midrst_state", dbg8, 2'd0);
        chk("midrst_locked", locked8, 1'b0);
        rst = 1'b1;
        send(1, 3'd3, 0);
        chk("midrst_seed_match", match8, 1'b0);
        send(1, 3'd5, 0);
        send(1, 3'd0, 0);
        chk("midrst_not_yet", locked8, 1'b0);
        send(1, 3'd2, 0);
        chk("midrst_relock", locked8, 1'b1);

        // randomized stream against the model
        do_reset();
        repeat (3000) begin
            rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            in_valid = ($urandom_range(0, 9) < 8);
            err_clr = ($urandom_range(0, 29) == 0);
            if (m_phase >= 0 && $urandom_range(0, 9) < 8)
                in_data = pat[(m_phase + 1) % 4];
            else
                in_data = 3'($urandom_range(0, 7));
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
